// File: rtl/xadac_sb_if.sv
// Issue/retire/status bundle between an instruction issuer and the xadac scoreboard.
// The master issues and retires; the slave (the scoreboard) answers with ready and occupancy.
interface xadac_sb_if #(
  parameter int NoRs         = 2,
  parameter int NoVs         = 3,
  parameter int IdWidth      = 4,
  parameter int RegAddrWidth = 5,
  parameter int VecAddrWidth = 5
);
  localparam int SbLen = 2**IdWidth;

  logic                         iss_valid_i;
  logic                         iss_ready_o;
  logic [IdWidth-1:0]           iss_id_i;
  logic                         iss_rd_clobber_i;
  logic [RegAddrWidth-1:0]      iss_rd_addr_i;
  logic                         iss_vd_clobber_i;
  logic [VecAddrWidth-1:0]      iss_vd_addr_i;
  logic [NoRs-1:0]              iss_rs_read_i;
  logic [NoRs*RegAddrWidth-1:0] iss_rs_addr_i;
  logic [NoVs-1:0]              iss_vs_read_i;
  logic [NoVs*VecAddrWidth-1:0] iss_vs_addr_i;
  logic                         ret_valid_i;
  logic [IdWidth-1:0]           ret_id_i;
  logic [SbLen-1:0]             busy_o;
  logic [IdWidth:0]             count_o;
  logic                         empty_o;
  logic                         full_o;
  logic                         err_o;

  modport master (
    output iss_valid_i, iss_id_i, iss_rd_clobber_i, iss_rd_addr_i,
           iss_vd_clobber_i, iss_vd_addr_i, iss_rs_read_i, iss_rs_addr_i,
           iss_vs_read_i, iss_vs_addr_i, ret_valid_i, ret_id_i,
    input  iss_ready_o, busy_o, count_o, empty_o, full_o, err_o
  );

  modport slave (
    input  iss_valid_i, iss_id_i, iss_rd_clobber_i, iss_rd_addr_i,
           iss_vd_clobber_i, iss_vd_addr_i, iss_rs_read_i, iss_rs_addr_i,
           iss_vs_read_i, iss_vs_addr_i, ret_valid_i, ret_id_i,
    output iss_ready_o, busy_o, count_o, empty_o, full_o, err_o
  );
endinterface

// File: rtl/xadac_sb.sv
// Per-ID scoreboard tracking pending scalar/vector destinations; RAW/WAW/ID-reuse gate issue.
// State updates one cycle after accept/retire; ready is combinational, retire is never stalled.
module xadac_sb #(
  parameter int NoRs         = 2,
  parameter int NoVs         = 3,
  parameter int IdWidth      = 4,
  parameter int RegAddrWidth = 5,
  parameter int VecAddrWidth = 5,
  parameter bit Bypass       = 1'b1
) (
  input logic       clk_i,
  input logic       rst_i,
  xadac_sb_if.slave sb
);
  localparam int SbLen = 2**IdWidth;

  logic [SbLen-1:0]        valid_q;
  logic [SbLen-1:0]        rd_clob_q;
  logic [SbLen-1:0]        vd_clob_q;
  logic [RegAddrWidth-1:0] rd_addr_q [SbLen];
  logic [VecAddrWidth-1:0] vd_addr_q [SbLen];
  logic [IdWidth:0]        count_q;
  logic                    err_q;

  logic [SbLen-1:0] visible;
  logic [SbLen-1:0] conflict;
  logic             full;
  logic             accept;
  logic             ret_hit;

  // With bypass, the entry retiring this cycle no longer blocks anything.
  always_comb begin
    visible = valid_q;
    if (Bypass && sb.ret_valid_i) visible[sb.ret_id_i] = 1'b0;
  end

  always_comb begin
    conflict = '0;
    for (int e = 0; e < SbLen; e++) begin
      if (rd_clob_q[e] && sb.iss_rd_clobber_i && sb.iss_rd_addr_i != '0 &&
          sb.iss_rd_addr_i == rd_addr_q[e])
        conflict[e] = 1'b1;
      if (vd_clob_q[e] && sb.iss_vd_clobber_i && sb.iss_vd_addr_i == vd_addr_q[e])
        conflict[e] = 1'b1;
      for (int j = 0; j < NoRs; j++) begin
        if (rd_clob_q[e] && sb.iss_rs_read_i[j] &&
            sb.iss_rs_addr_i[j*RegAddrWidth +: RegAddrWidth] != '0 &&
            sb.iss_rs_addr_i[j*RegAddrWidth +: RegAddrWidth] == rd_addr_q[e])
          conflict[e] = 1'b1;
      end
      for (int j = 0; j < NoVs; j++) begin
        if (vd_clob_q[e] && sb.iss_vs_read_i[j] &&
            sb.iss_vs_addr_i[j*VecAddrWidth +: VecAddrWidth] == vd_addr_q[e])
          conflict[e] = 1'b1;
      end
    end
  end

  assign full    = (count_q == (IdWidth+1)'(SbLen));
  assign accept  = sb.iss_valid_i && sb.iss_ready_o;
  assign ret_hit = sb.ret_valid_i && valid_q[sb.ret_id_i];

  assign sb.iss_ready_o = !full && !visible[sb.iss_id_i] && !(|(conflict & visible));
  assign sb.busy_o      = valid_q;
  assign sb.count_o     = count_q;
  assign sb.empty_o     = (count_q == '0);
  assign sb.full_o      = full;
  assign sb.err_o       = err_q;

  // Accept is applied after retire so a same-ID retire+reissue leaves the entry live.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (ret_hit) valid_q[sb.ret_id_i] <= 1'b0;
      if (accept)  valid_q[sb.iss_id_i] <= 1'b1;
      if (sb.ret_valid_i && !ret_hit) err_q <= 1'b1;
      count_q <= count_q + (IdWidth+1)'(accept) - (IdWidth+1)'(ret_hit);
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept && !rst_i) begin
      rd_clob_q[sb.iss_id_i] <= sb.iss_rd_clobber_i;
      rd_addr_q[sb.iss_id_i] <= sb.iss_rd_addr_i;
      vd_clob_q[sb.iss_id_i] <= sb.iss_vd_clobber_i;
      vd_addr_q[sb.iss_id_i] <= sb.iss_vd_addr_i;
    end
  end
endmodule
